// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants and schedule helper functions.
// Used by the message schedule today and intended for reuse by the compression core.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int unsigned SHA256_ROUNDS = 64;

  localparam word_t SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr32(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sha_s0_sched(input word_t x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sha_s1_sched(input word_t x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Combinational next schedule word: W[t+16] from window taps W[t], W[t+1], W[t+9], W[t+14].
module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] w16
);

  assign w16 = sha_s1_sched(w14) + w9 + sha_s0_sched(w1) + w0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: streams W[t]/K[t] for one block from a 16-word sliding window.
// Optional macro SHA256_WK_SUM_EN adds a registered wk_o = W[t] + K[t] output.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [511:0] block_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  w_o,
  output logic [31:0]  k_o,
  output logic [5:0]   round_o,
  output logic         last_o
`ifdef SHA256_WK_SUM_EN
  ,
  output logic [31:0]  wk_o
`endif
);

  if (ROUNDS != SHA256_ROUNDS) begin : g_bad_rounds
    $error("sha256_msg_sched: ROUNDS must be 64");
  end

  state_t     state_q, state_d;
  word_t      window_q [16];
  word_t      window_d [16];
  logic [5:0] round_q, round_d;
  word_t      w_next;
  logic       run;
  logic       xfer;
  logic       last_round;
  logic       load_hs;

  sha256_sched_word u_sched_word (
    .w0  (window_q[0]),
    .w1  (window_q[1]),
    .w9  (window_q[9]),
    .w14 (window_q[14]),
    .w16 (w_next)
  );

  assign run        = (state_q == RUN);
  assign xfer       = run & out_ready;
  assign last_round = (round_q == 6'(ROUNDS - 1));
  assign load_hs    = (state_q == IDLE) & load_valid;

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    round_d  = round_q;
    if (clear) begin
      state_d  = IDLE;
      window_d = '{default: '0};
      round_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            for (int i = 0; i < 16; i++) begin
              window_d[i] = block_i[511 - 32 * i -: 32];
            end
            round_d = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            for (int i = 0; i < 15; i++) begin
              window_d[i] = window_q[i + 1];
            end
            window_d[15] = w_next;
            // Round is parked at 0 on exit so round_o reads 0 while idle.
            if (last_round) begin
              state_d = IDLE;
              round_d = '0;
            end else begin
              round_d = round_q + 6'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      window_q <= '{default: '0};
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      round_q  <= round_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign out_valid  = run;
  assign w_o        = run ? window_q[0] : '0;
  assign k_o        = run ? SHA256_K[round_q] : '0;
  assign round_o    = round_q;
  assign last_o     = run & last_round;

`ifdef SHA256_WK_SUM_EN
  word_t wk_q, wk_d;

  // Precompute the next W+K one cycle ahead so the round sees it with out_valid.
  always_comb begin
    wk_d = wk_q;
    if (clear) begin
      wk_d = '0;
    end else if (load_hs) begin
      wk_d = block_i[511:480] + SHA256_K[0];
    end else if (xfer) begin
      wk_d = last_round ? '0 : window_q[1] + SHA256_K[round_q + 6'd1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wk_q <= '0;
    end else begin
      wk_q <= wk_d;
    end
  end

  assign wk_o = wk_q;
`else
  logic unused_hs;
  assign unused_hs = load_hs ^ xfer;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched; define SHA256_WK_SUM_EN to also check wk_o.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         load_valid;
  logic         load_ready;
  logic [511:0] block_i;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  w_o;
  logic [31:0]  k_o;
  logic [5:0]   round_o;
  logic         last_o;
`ifdef SHA256_WK_SUM_EN
  logic [31:0]  wk_o;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] mw [64];
  logic [31:0] got_w [64];
  logic [31:0] got_k [64];
  logic        got_last [64];
  logic [31:0] got_wk [64];
  logic [31:0] ref_w [64];

  typedef struct {
    int          t;
    bit          has_w;
    logic [31:0] w;
    logic [31:0] k;
    logic        last;
  } vec_t;

  vec_t vt [6];

  sha256_msg_sched dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .block_i    (block_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .w_o        (w_o),
    .k_o        (k_o),
    .round_o    (round_o),
    .last_o     (last_o)
`ifdef SHA256_WK_SUM_EN
    ,
    .wk_o       (wk_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] trotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ts0(input logic [31:0] x);
    return trotr(x, 7) ^ trotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ts1(input logic [31:0] x);
    return trotr(x, 17) ^ trotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32 * i +: 32] = $urandom();
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full 64-word schedule straight from the recurrence.
  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) mw[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++) mw[t] = ts1(mw[t - 2]) + mw[t - 7] + ts0(mw[t - 15]) + mw[t - 16];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [511:0] blk);
    int n = 0;
    while (!load_ready && n < 200) begin
      step();
      n++;
    end
    chk("load_ready_wait", {31'b0, load_ready}, 32'd1);
    block_i    = blk;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    block_i    = rand_block();
  endtask

  task automatic collect(input bit stall);
    int          cnt = 0;
    int          cyc = 0;
    bit          pstall = 0;
    bit          v;
    logic [31:0] pw, pk;
    logic [5:0]  pr;
    while (cnt < 64 && cyc < 1000) begin
      v = out_valid;
      chk($sformatf("out_valid[%0d]", cnt), {31'b0, out_valid}, 32'd1);
      if (pstall) begin
        chk($sformatf("stall_w[%0d]", cnt), w_o, pw);
        chk($sformatf("stall_k[%0d]", cnt), k_o, pk);
        chk($sformatf("stall_round[%0d]", cnt), {26'b0, round_o}, {26'b0, pr});
      end
      chk($sformatf("w[%0d]", cnt), w_o, mw[cnt]);
      chk($sformatf("k[%0d]", cnt), k_o, TK[cnt]);
      chk($sformatf("round[%0d]", cnt), {26'b0, round_o}, cnt);
      chk($sformatf("last[%0d]", cnt), {31'b0, last_o}, {31'b0, (cnt == 63)});
`ifdef SHA256_WK_SUM_EN
      chk($sformatf("wk[%0d]", cnt), wk_o, mw[cnt] + TK[cnt]);
      got_wk[cnt] = wk_o;
`endif
      got_w[cnt]    = w_o;
      got_k[cnt]    = k_o;
      got_last[cnt] = last_o;
      out_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      load_valid = (cnt < 63) ? 1'($urandom_range(0, 1)) : 1'b0;
      pw = w_o;
      pk = k_o;
      pr = round_o;
      pstall = !out_ready;
      step();
      cyc++;
      if (v && out_ready) cnt++;
    end
    load_valid = 1'b0;
    chk("collect_count", cnt, 32'd64);
    chk("done_load_ready", {31'b0, load_ready}, 32'd1);
    chk("done_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  logic [511:0] abc, blk_a, blk_b;
  logic [31:0]  mwa [64];
  logic [31:0]  mwb [64];

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    load_valid = 1'b0;
    out_ready  = 1'b0;
    block_i    = '0;
    abc        = {32'h61626380, 448'h0, 32'h00000018};
    vt[0] = '{0,  1'b1, 32'h61626380, 32'h428a2f98, 1'b0};
    vt[1] = '{1,  1'b1, 32'h00000000, 32'h71374491, 1'b0};
    vt[2] = '{15, 1'b1, 32'h00000018, 32'hc19bf174, 1'b0};
    vt[3] = '{16, 1'b1, 32'h61626380, 32'he49b69c1, 1'b0};
    vt[4] = '{17, 1'b1, 32'h000f0000, 32'hefbe4786, 1'b0};
    vt[5] = '{63, 1'b0, 32'h00000000, 32'hc67178f2, 1'b1};
    #12 rst = 1'b0;
    step();

    chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_w", w_o, 32'd0);
    chk("rst_k", k_o, 32'd0);
    chk("rst_round", {26'b0, round_o}, 32'd0);
    chk("rst_last", {31'b0, last_o}, 32'd0);
`ifdef SHA256_WK_SUM_EN
    chk("rst_wk", wk_o, 32'd0);
`endif

    // "abc" block, no stalls, then table of known values.
    build_model(abc);
    load_block(abc);
    collect(1'b0);
    ref_w = got_w;
    for (int i = 0; i < 6; i++) begin
      if (vt[i].has_w) chk($sformatf("abc_w%0d", vt[i].t), got_w[vt[i].t], vt[i].w);
      chk($sformatf("abc_k%0d", vt[i].t), got_k[vt[i].t], vt[i].k);
      chk($sformatf("abc_last%0d", vt[i].t), {31'b0, got_last[vt[i].t]}, {31'b0, vt[i].last});
    end
`ifdef SHA256_WK_SUM_EN
    chk("abc_wk0", got_wk[0], 32'ha3ec9318);
`endif

    // Same block with random stalls must produce the identical sequence.
    load_block(abc);
    collect(1'b1);
    for (int i = 0; i < 64; i++) chk($sformatf("stall_seq[%0d]", i), got_w[i], ref_w[i]);

    repeat (4) begin
      blk_a = rand_block();
      build_model(blk_a);
      load_block(blk_a);
      collect(1'b1);
    end

    // Back-to-back with load_valid held high across the block boundary.
    begin
      int xfers = 0, hs = 0, c_last = -1, c_w0 = -1;
      bit hsnow, xnow;
      blk_a = rand_block();
      blk_b = rand_block();
      build_model(blk_a);
      mwa = mw;
      build_model(blk_b);
      mwb = mw;
      block_i    = blk_a;
      load_valid = 1'b1;
      out_ready  = 1'b1;
      for (int c = 0; c < 200; c++) begin
        if (out_valid && xfers < 128) begin
          chk($sformatf("b2b_w[%0d]", xfers), w_o, (xfers < 64) ? mwa[xfers] : mwb[xfers - 64]);
          if (xfers == 64 && c_w0 < 0) begin
            c_w0 = c;
            chk("b2b_w0_round", {26'b0, round_o}, 32'd0);
          end
        end
        hsnow = load_valid && load_ready;
        xnow  = out_valid && out_ready;
        if (xnow && xfers == 63) c_last = c;
        step();
        if (hsnow) begin
          hs++;
          if (hs == 1) block_i = blk_b;
          else load_valid = 1'b0;
        end
        if (xnow) xfers++;
      end
      load_valid = 1'b0;
      chk("b2b_transfers", xfers, 32'd128);
      chk("b2b_loads", hs, 32'd2);
      chk("b2b_gap", c_w0 - c_last, 32'd2);
    end

    // clear at round 20.
    begin
      int n = 0;
      build_model(abc);
      load_block(abc);
      out_ready = 1'b1;
      while (round_o != 6'd20 && n < 100) begin
        step();
        n++;
      end
      chk("clr_reach20", {26'b0, round_o}, 32'd20);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_out_valid", {31'b0, out_valid}, 32'd0);
      chk("clr_load_ready", {31'b0, load_ready}, 32'd1);
      chk("clr_w", w_o, 32'd0);
      chk("clr_round", {26'b0, round_o}, 32'd0);
`ifdef SHA256_WK_SUM_EN
      chk("clr_wk", wk_o, 32'd0);
`endif
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_idle_load_ready", {31'b0, load_ready}, 32'd1);
      blk_a = rand_block();
      build_model(blk_a);
      load_block(blk_a);
      collect(1'b0);
    end

    // Asynchronous reset mid-cycle at round 40.
    begin
      int n = 0;
      build_model(abc);
      load_block(abc);
      out_ready = 1'b1;
      while (round_o != 6'd40 && n < 100) begin
        step();
        n++;
      end
      chk("rst_reach40", {26'b0, round_o}, 32'd40);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_load_ready", {31'b0, load_ready}, 32'd1);
      chk("arst_w", w_o, 32'd0);
      chk("arst_k", k_o, 32'd0);
      chk("arst_round", {26'b0, round_o}, 32'd0);
      chk("arst_last", {31'b0, last_o}, 32'd0);
`ifdef SHA256_WK_SUM_EN
      chk("arst_wk", wk_o, 32'd0);
`endif
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        chk($sformatf("arst_quiet[%0d]", i), {31'b0, out_valid}, 32'd0);
      end
      blk_a = rand_block();
      build_model(blk_a);
      load_block(blk_a);
      collect(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
